axi4_lite_slave_mem: RTL

//  Parametrised AXI4-Lite slave memory: byte-strobed word array behind independent AW/W/B and AR/R channels.

---
 rtl/axi4_lite_pkg.sv | 13 +
 rtl/axi4_lite_rd_pipe.sv | 65 ++++++
 rtl/axi4_lite_slave_mem.sv | 118 +++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: response encoding and address-decode helpers shared by the AXI4-Lite slave memory
package axi4_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction
  function automatic int unsigned off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int unsigned off);
    return addr >> off;
  endfunction
endpackage

// File: rtl/axi4_lite_rd_pipe.sv
// axi4_lite_rd_pipe: single-outstanding read slot with a fixed latency counter and registered R outputs
module axi4_lite_rd_pipe
  import axi4_lite_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    arvalid,
  input  logic                    rready,
  input  logic [P_DATA_WIDTH-1:0] word,
  input  resp_t                   resp,
  output logic                    arready,
  output logic                    rvalid,
  output logic [P_DATA_WIDTH-1:0] rdata,
  output resp_t                   rresp
);
  localparam int CW = P_RD_LATENCY > 1 ? $clog2(P_RD_LATENCY) : 1;
  logic busy_q, busy_d, rvalid_q, rvalid_d, arready_q, arready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t rresp_q, rresp_d;
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (arvalid && arready_q) begin
      busy_d  = 1'b1;
      cnt_d   = CW'(P_RD_LATENCY - 1);
      rdata_d = word;
      rresp_d = resp;
    end else if (busy_q && !rvalid_q) begin
      rvalid_d = cnt_q == '0;
      cnt_d    = cnt_q - CW'(cnt_q != '0);
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      busy_d   = 1'b0;
    end
    arready_d = !busy_d;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      arready_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
    end
  end
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule

// File: rtl/axi4_lite_slave_mem.sv
// axi4_lite_slave_mem: byte-strobed AXI4-Lite word memory with range/privilege checking
// and a programmable read latency; one outstanding write and one outstanding read.
module axi4_lite_slave_mem
  import axi4_lite_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DEPTH      = 256,
  parameter int P_RD_LATENCY = 1,
  parameter int P_PROT_CHECK = 0
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [P_ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [P_DATA_WIDTH-1:0]   wdata,
  input  logic [P_DATA_WIDTH/8-1:0] wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output resp_t                     bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [P_ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [P_DATA_WIDTH-1:0]   rdata,
  output resp_t                     rresp
);
  localparam int unsigned SW  = strb_width(P_DATA_WIDTH);
  localparam int unsigned OFF = off_bits(P_DATA_WIDTH);
  localparam int          IW  = $clog2(P_DEPTH);
  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
  logic awready_q, awready_d, wready_q, wready_d, awpriv_q, awpriv_d;
  logic [P_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d, rd_word;
  logic [SW-1:0] wstrb_q, wstrb_d;
  resp_t bresp_q, bresp_d, rd_resp;
  logic [63:0] widx, ridx;
  logic aw_hs, w_hs, commit, w_err, r_err, unused;
  assign unused = ^{awprot[2:1], arprot[2:1]};
  always_comb begin
    aw_hs     = awvalid && awready_q;
    w_hs      = wvalid && wready_q;
    widx      = addr_to_index(64'(awaddr_q), OFF);
    ridx      = addr_to_index(64'(araddr), OFF);
    commit    = aw_held_q && w_held_q;
    w_err     = widx >= 64'(P_DEPTH) || (P_PROT_CHECK != 0 && !awpriv_q);
    r_err     = ridx >= 64'(P_DEPTH) || (P_PROT_CHECK != 0 && !arprot[0]);
    rd_resp   = r_err ? SLVERR : OKAY;
    rd_word   = r_err ? '0 : mem_q[ridx[IW-1:0]];
    aw_held_d = !commit && (aw_held_q || aw_hs);
    w_held_d  = !commit && (w_held_q || w_hs);
    awaddr_d  = aw_hs ? awaddr : awaddr_q;
    awpriv_d  = aw_hs ? awprot[0] : awpriv_q;
    wdata_d   = w_hs ? wdata : wdata_q;
    wstrb_d   = w_hs ? wstrb : wstrb_q;
    bvalid_d  = commit || (bvalid_q && !bready);
    bresp_d   = commit ? (w_err ? SLVERR : OKAY) : bresp_q;
    // readies look at next-state so no handshake can land on a full slot
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      awpriv_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      awpriv_q  <= awpriv_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (commit && !w_err)
      for (int i = 0; i < int'(SW); i++)
        if (wstrb_q[i]) mem_q[widx[IW-1:0]][i*8 +: 8] <= wdata_q[i*8 +: 8];
  end
  axi4_lite_rd_pipe #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_RD_LATENCY(P_RD_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .arst_n (arst_n),
    .arvalid(arvalid),
    .rready (rready),
    .word   (rd_word),
    .resp   (rd_resp),
    .arready(arready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .rresp  (rresp)
  );
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
endmodule
